dcd_rate_controller: RTL and testbench
======================================

# dcd_rate_controller

Rate sequencer for the dynamic clock divider: accepts divide-value change requests over a valid/ready handshake, clamps them to a legal range, and ramps the divider's `i_DIV_VALUE` toward the target in bounded steps. Updates are applied only at divider tick boundaries, so no output period is ever truncated. It sits beside `dynamic_clock_divider`, drives its `i_DIV_VALUE` and `i_ENABLE`, and observes its `o_ENABLE_OUT` as the tick.

## Interface
- `WIDTH`, 32: divide-value width.
- `RESET_DIV`, 4: `o_DIV_VALUE` after reset; must lie in [`MIN_DIV`, `MAX_DIV`].
- `MIN_DIV`, 2: smallest legal divide value.
- `MAX_DIV`, 1000: largest legal divide value.
- `RAMP_STEP`, 2: maximum change per update event; must be ≥1.
- `SETTLE_TICKS`, 2: update events to wait after the target is reached.
- `i_CLK`  in  1  system clock; all logic on rising edge.
- `i_RESET_N`  in  1  asynchronous, active-low reset.
- `i_RUN`  in  1  divider run request.
- `i_TICK`  in  1  divider `o_ENABLE_OUT`.
- `i_REQ_VALID`  in  1  new target offered.
- `i_REQ_DIV`  in  WIDTH  requested divide value.
- `o_REQ_READY`  out  1  high only in IDLE.
- `i_ABORT`  in  1  cancel an in-flight ramp.
- `o_DIV_VALUE`  out  WIDTH  registered value to the divider.
- `o_DIV_ENABLE`  out  1  registered copy of `i_RUN`.
- `o_BUSY`  out  1  state is not IDLE.
- `o_DONE`  out  1  one-cycle pulse when the target is reached and settled.
- `o_CLAMPED`  out  1  one-cycle pulse when an accepted request was clamped.

## Operation
- **Reset values:** `o_DIV_VALUE`=`RESET_DIV`; `o_DIV_ENABLE`, `o_BUSY`, `o_DONE`, `o_CLAMPED` = 0; state IDLE, so `o_REQ_READY`=1. Reset is asynchronous: asserting it at any point, including mid-ramp, forces these values immediately.
- **Update event:** `i_TICK & o_DIV_ENABLE`, or every cycle while `o_DIV_ENABLE`=0, because an idle divider has no period to protect.
- **IDLE:**
  - Accept when `i_REQ_VALID & o_REQ_READY`.
  - Target = `i_REQ_DIV` clamped to [`MIN_DIV`, `MAX_DIV`]; `o_CLAMPED` pulses if the value changed.
  - If target == `o_DIV_VALUE`: `o_DONE` pulses next cycle and the state stays IDLE.
  - Otherwise go to RAMP.
  - `i_ABORT` is ignored in IDLE, including when it coincides with a request.
- **RAMP:** on each update event, `o_DIV_VALUE` moves toward target by min(`RAMP_STEP`, |target−value|).
  - Use unsigned WIDTH-bit compare and subtract. Overshoot is impossible, so no overflow.
  - When the updated value equals target, load the settle counter with `SETTLE_TICKS` and go to SETTLE.
  - If `SETTLE_TICKS`=0, go directly to IDLE and pulse `o_DONE`.
- **SETTLE:** decrement the counter on each update event. On reaching 0, go to IDLE and pulse `o_DONE`.
- **Abort:** `i_ABORT` in RAMP or SETTLE takes the state to IDLE on the next edge. `o_DIV_VALUE` keeps its current value, `o_DONE` does not pulse, and the target is discarded. If abort and an update event coincide, abort wins and that update is not applied.
- **`i_RUN` toggling:** allowed mid-ramp; the update-event source switches from the next cycle.

## Timing
- Request accepted at edge N: state RAMP and `o_REQ_READY`=0 from N+1; `o_CLAMPED` high during cycle N+1 only.
- Update event sampled at edge M: new `o_DIV_VALUE` visible from M+1. This is the same cycle the divider starts its next period.
- `o_DONE` is high for exactly the one cycle after the terminating edge; `o_REQ_READY` returns high in that same cycle.
- `o_DIV_ENABLE` lags `i_RUN` by one cycle.
- `o_REQ_READY` and `o_BUSY` decode the state register only; no combinational input-to-output paths.

## Structure
- Shared package/header `dcd_pkg`: state encodings (IDLE, RAMP, SETTLE) and default constants (`MIN_DIV`, `MAX_DIV`, `RAMP_STEP`).
- Single module. The clamp/step arithmetic is small enough to stay inline; no sub-module.
- The top level instantiates `dynamic_clock_divider` alongside this block and connects `o_DIV_VALUE`, `o_DIV_ENABLE` and `i_TICK`.

## Test plan
Default parameters, `i_RUN`=1, `i_TICK` every 4 cycles, unless stated otherwise.
- **Reset:** release reset → `o_DIV_VALUE`=4, `o_DIV_ENABLE`=0, `o_REQ_READY`=1, `o_BUSY`=0, no pulses.
- **Ramp up:** request 10 → value 4→6→8→10, each change one cycle after ticks 1–3; `o_DONE` pulses once, one cycle after tick 5; `o_BUSY` is high throughout.
- **Clamp:** request 0 → `o_CLAMPED` pulse, target 2, value 4→2 after one tick, done after 2 further ticks.
- **Equal target:** request 4 → `o_DONE` the next cycle, `o_BUSY` never high.
- **Abort:** request 20, `i_ABORT` after tick 2 → IDLE next cycle, value held at 8, no `o_DONE`.
- **Divider idle and mid-ramp reset:**
  - With `i_RUN`=0, request 9 → value 6, 8, 9 on consecutive cycles, done 2 cycles later.
  - Repeat with `i_RESET_N` low mid-ramp → immediate return to reset values.

Source files
------------

// File: rtl/dcd_pkg.sv
// Shared definitions for the dynamic clock divider rate sequencer.
// State encoding and default divide-value limits.
package dcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } dcd_state_e;

  localparam int DCD_MIN_DIV   = 2;
  localparam int DCD_MAX_DIV   = 1000;
  localparam int DCD_RAMP_STEP = 2;

endpackage

// File: rtl/dcd_rate_controller.sv
// Ramps the divider's divide value toward a requested target,
// stepping only on divider tick boundaries.
module dcd_rate_controller
  import dcd_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int RESET_DIV    = 4,
  parameter int MIN_DIV      = DCD_MIN_DIV,
  parameter int MAX_DIV      = DCD_MAX_DIV,
  parameter int RAMP_STEP    = DCD_RAMP_STEP,
  parameter int SETTLE_TICKS = 2
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_RUN,
  input  logic             i_TICK,
  input  logic             i_REQ_VALID,
  input  logic [WIDTH-1:0] i_REQ_DIV,
  output logic             o_REQ_READY,
  input  logic             i_ABORT,
  output logic [WIDTH-1:0] o_DIV_VALUE,
  output logic             o_DIV_ENABLE,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_CLAMPED
);

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_DIV);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(RAMP_STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_DIV);
  localparam logic [31:0]      SET_W  = 32'(SETTLE_TICKS);

  dcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [31:0]      settle_q, settle_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             clamp_q, clamp_d;

  logic             upd;
  logic [WIDTH-1:0] req_c;
  logic             up;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] nxt;

  // A stopped divider has no period to protect.
  assign upd = en_q ? i_TICK : 1'b1;

  always_comb begin
    req_c = i_REQ_DIV;
    if (i_REQ_DIV < MIN_W) req_c = MIN_W;
    if (i_REQ_DIV > MAX_W) req_c = MAX_W;
  end

  always_comb begin
    up   = tgt_q > div_q;
    diff = up ? (tgt_q - div_q) : (div_q - tgt_q);
    step = (diff < STEP_W) ? diff : STEP_W;
    nxt  = up ? (div_q + step) : (div_q - step);
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    en_d     = i_RUN;
    done_d   = 1'b0;
    clamp_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_REQ_VALID) begin
          clamp_d = (req_c != i_REQ_DIV);
          tgt_d   = req_c;
          if (req_c == div_q) done_d  = 1'b1;
          else                state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (i_ABORT) begin
          state_d = ST_IDLE;
        end else if (upd) begin
          div_d = nxt;
          if (nxt == tgt_q) begin
            if (SETTLE_TICKS == 0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              settle_d = SET_W;
              state_d  = ST_SETTLE;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (i_ABORT) begin
          state_d = ST_IDLE;
        end else if (upd) begin
          settle_d = settle_q - 32'd1;
          if (settle_q <= 32'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q  <= ST_IDLE;
      div_q    <= RST_W;
      tgt_q    <= RST_W;
      settle_q <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tgt_q    <= tgt_d;
      settle_q <= settle_d;
      en_q     <= en_d;
      done_q   <= done_d;
      clamp_q  <= clamp_d;
    end
  end

  assign o_REQ_READY  = (state_q == ST_IDLE);
  assign o_BUSY       = (state_q != ST_IDLE);
  assign o_DIV_VALUE  = div_q;
  assign o_DIV_ENABLE = en_q;
  assign o_DONE       = done_q;
  assign o_CLAMPED    = clamp_q;

endmodule

// File: tb/tb_dcd_rate_controller.sv
// Bench for dcd_rate_controller: vector table, value-change
// scoreboard, abort and mid-ramp reset sequences.
module tb_dcd_rate_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        tick = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_div = '0;
  logic        abort = 1'b0;
  logic        ready;
  logic [31:0] div_value;
  logic        div_en;
  logic        busy;
  logic        done;
  logic        clamped;

  int errors = 0;
  int checks = 0;

  dcd_rate_controller dut (
    .i_CLK        (clk),
    .i_RESET_N    (rst_n),
    .i_RUN        (run),
    .i_TICK       (tick),
    .i_REQ_VALID  (req_valid),
    .i_REQ_DIV    (req_div),
    .o_REQ_READY  (ready),
    .i_ABORT      (abort),
    .o_DIV_VALUE  (div_value),
    .o_DIV_ENABLE (div_en),
    .o_BUSY       (busy),
    .o_DONE       (done),
    .o_CLAMPED    (clamped)
  );

  always #5 clk = ~clk;

  int tick_cnt = 0;
  always @(posedge clk) begin
    #2;
    tick_cnt = (tick_cnt + 1) % 4;
    tick = (tick_cnt == 0);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [31:0] prev_val = 32'd4;
  logic        ev_s = 1'b1;
  int          ev_gap = 0;
  int          done_cnt = 0;
  int          done_gap = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (div_value !== prev_val) begin
        chk("change_on_event", {31'd0, ev_s}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_change", div_value, prev_val);
        end else begin
          chk("div_step", div_value, exp_q.pop_front());
        end
        ev_gap = 0;
      end else if (ev_s) begin
        ev_gap++;
      end
      if (done) begin
        done_cnt++;
        done_gap = ev_gap;
      end
    end
    prev_val = div_value;
    ev_s = tick | ~div_en;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        run;
    logic [31:0] req;
    logic        clamped;
    int          n;
    logic [31:0] vals[4];
  } vec_t;

  vec_t tbl[9];

  task automatic wait_done(input int d0, input logic [31:0] last);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      step();
      k++;
    end
    chk("done_seen", {31'd0, done_cnt != d0}, 32'd1);
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_value", div_value, last);
    chk("done_settle_gap", done_gap, 32'd2);
    chk("queue_drained", exp_q.size(), 32'd0);
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d0;
    run = v.run;
    repeat (3) step();
    chk("div_enable", {31'd0, div_en}, {31'd0, v.run});
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.vals[i]);
    d0 = done_cnt;
    req_div = v.req;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("clamped_pulse", {31'd0, clamped}, {31'd0, v.clamped});
    chk("busy_after_acc", {31'd0, busy}, {31'd0, v.n != 0});
    chk("ready_after_acc", {31'd0, ready}, {31'd0, v.n == 0});
    if (v.n == 0) begin
      chk("equal_done", {31'd0, done}, 32'd1);
      step();
      chk("equal_done_once", {31'd0, done}, 32'd0);
      chk("equal_busy", {31'd0, busy}, 32'd0);
    end else begin
      step();
      chk("clamped_once", {31'd0, clamped}, 32'd0);
      wait_done(d0, v.vals[v.n-1]);
    end
    chk("done_count", done_cnt - d0, 32'd1);
    if (errors != 0) $display("vector %0d done with errors=%0d", idx, errors);
  endtask

  task automatic wait_value(input logic [31:0] v);
    int k;
    k = 0;
    while (div_value != v && k < 40) begin
      step();
      k++;
    end
    chk("reach_value", div_value, v);
  endtask

  initial begin
    int d0;
    tbl[0] = '{1'b1, 32'd10, 1'b0, 3, '{32'd6, 32'd8, 32'd10, 32'd0}};
    tbl[1] = '{1'b1, 32'd4,  1'b0, 3, '{32'd8, 32'd6, 32'd4, 32'd0}};
    tbl[2] = '{1'b1, 32'd0,  1'b1, 1, '{32'd2, 32'd0, 32'd0, 32'd0}};
    tbl[3] = '{1'b1, 32'd2,  1'b0, 0, '{32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[4] = '{1'b0, 32'd9,  1'b0, 4, '{32'd4, 32'd6, 32'd8, 32'd9}};
    tbl[5] = '{1'b1, 32'd4,  1'b0, 3, '{32'd7, 32'd5, 32'd4, 32'd0}};
    tbl[6] = '{1'b0, 32'd1,  1'b1, 1, '{32'd2, 32'd0, 32'd0, 32'd0}};
    tbl[7] = '{1'b0, 32'd2,  1'b0, 0, '{32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[8] = '{1'b1, 32'd0,  1'b1, 0, '{32'd0, 32'd0, 32'd0, 32'd0}};

    repeat (3) step();
    chk("rst_div_held", div_value, 32'd4);
    rst_n = 1'b1;
    step();
    chk("rst_div", div_value, 32'd4);
    chk("rst_en", {31'd0, div_en}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_clamped", {31'd0, clamped}, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // Abort mid-ramp: value freezes, no done.
    run = 1'b1;
    repeat (3) step();
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd6);
    d0 = done_cnt;
    req_div = 32'd20;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    wait_value(32'd6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    repeat (12) step();
    chk("abort_hold", div_value, 32'd6);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // Abort coinciding with a request in IDLE is ignored.
    exp_q.push_back(32'd8);
    d0 = done_cnt;
    req_div = 32'd8;
    req_valid = 1'b1;
    abort = 1'b1;
    step();
    req_valid = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd1);
    wait_done(d0, 32'd8);

    // Asynchronous reset in the middle of an idle-divider ramp.
    run = 1'b0;
    repeat (3) step();
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd12);
    req_div = 32'd20;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    wait_value(32'd12);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_div", div_value, 32'd4);
    chk("mid_rst_en", {31'd0, div_en}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_clamped", {31'd0, clamped}, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_rst_div", div_value, 32'd4);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
